// File: rtl/valu_seq_if.sv
// valu_seq_if: request/response bundle for the sequential vector ALU.
// The controller drives the master side; the ALU is the slave.
interface valu_seq_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 5,
    parameter int VLW   = $clog2(LANES + 1)
);
    logic                   start;
    logic [2:0]             ALUControl;
    logic [VLW-1:0]         vlen;
    logic [LANES*WIDTH-1:0] VsrcA;
    logic [LANES*WIDTH-1:0] VsrcB;
    logic                   busy;
    logic                   done;
    logic [LANES*WIDTH-1:0] VALUResult;
    logic [3:0]             ALUFlags;

    modport master (
        output start, ALUControl, vlen, VsrcA, VsrcB,
        input  busy, done, VALUResult, ALUFlags
    );

    modport slave (
        input  start, ALUControl, vlen, VsrcA, VsrcB,
        output busy, done, VALUResult, ALUFlags
    );
endinterface

// File: rtl/valu_seq.sv
// valu_seq: masked element-wise vector ALU with a start/busy/done handshake.
// Multiply is an iterative shift-add over all lanes, one bit per cycle.
module valu_seq #(
    parameter int WIDTH = 32,
    parameter int LANES = 5,
    parameter int VLW   = $clog2(LANES + 1)
) (
    input logic       clk,
    input logic       reset,
    valu_seq_if.slave bus
);
    localparam int LW = LANES * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t         state_q, state_d;
    logic [2:0]     ctrl_q, ctrl_d;
    logic [VLW-1:0] vlen_q, vlen_d;
    logic [LW-1:0]  a_q, a_d;
    logic [LW-1:0]  b_q, b_d;
    logic [LW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [LW-1:0]  res_q, res_d;
    logic [3:0]     flags_q, flags_d;

    logic [LW-1:0]  calc_res;
    logic [3:0]     calc_flags;

    // Per-lane result and masked flag aggregation from the latched operands
    always_comb begin
        logic [WIDTH-1:0] x, y, r;
        logic [WIDTH:0]   sum;
        logic             cy, ov, fn, fz, fc, fv;
        calc_res = '0;
        fn = 1'b0;
        fz = 1'b1;
        fc = 1'b0;
        fv = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            x   = a_q[i*WIDTH +: WIDTH];
            y   = b_q[i*WIDTH +: WIDTH];
            sum = '0;
            r   = '0;
            cy  = 1'b0;
            ov  = 1'b0;
            case (ctrl_q)
                OP_ADD: begin
                    sum = {1'b0, x} + {1'b0, y};
                    r   = sum[WIDTH-1:0];
                    cy  = sum[WIDTH];
                    ov  = (x[WIDTH-1] == y[WIDTH-1]) &&
                          (r[WIDTH-1] != x[WIDTH-1]);
                end
                OP_SUB: begin
                    sum = {1'b0, x} + {1'b0, ~y} + (WIDTH+1)'(1);
                    r   = sum[WIDTH-1:0];
                    cy  = sum[WIDTH];
                    ov  = (x[WIDTH-1] != y[WIDTH-1]) &&
                          (r[WIDTH-1] != x[WIDTH-1]);
                end
                OP_AND: r = x & y;
                OP_OR:  r = x | y;
                OP_XOR: r = x ^ y;
                OP_MUL: r = acc_q[i*WIDTH +: WIDTH] + (y[0] ? x : '0);
                default: r = '0;
            endcase
            if (VLW'(i) < vlen_q) begin
                calc_res[i*WIDTH +: WIDTH] = r;
                fn = fn | r[WIDTH-1];
                fz = fz & (r == '0);
                fc = fc | cy;
                fv = fv | ov;
            end
        end
        calc_flags = {fn, fz, fc, fv};
    end

    // Next-state, operand latching, multiplier stepping and result write
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        vlen_d  = vlen_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        flags_d = flags_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    ctrl_d = bus.ALUControl;
                    vlen_d = (bus.vlen > VLW'(LANES)) ? VLW'(LANES) : bus.vlen;
                    a_d    = bus.VsrcA;
                    b_d    = bus.VsrcB;
                    acc_d  = '0;
                    cnt_d  = '0;
                    state_d = (bus.ALUControl == OP_MUL) ? MUL : EXEC;
                end
            end
            EXEC: begin
                res_d   = calc_res;
                flags_d = calc_flags;
                state_d = DONE;
            end
            MUL: begin
                for (int i = 0; i < LANES; i++) begin
                    acc_d[i*WIDTH +: WIDTH] = acc_q[i*WIDTH +: WIDTH] +
                        (b_q[i*WIDTH] ? a_q[i*WIDTH +: WIDTH] : '0);
                    a_d[i*WIDTH +: WIDTH] = a_q[i*WIDTH +: WIDTH] << 1;
                    b_d[i*WIDTH +: WIDTH] = b_q[i*WIDTH +: WIDTH] >> 1;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    res_d   = calc_res;
                    flags_d = calc_flags;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ctrl_q  <= '0;
            vlen_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            vlen_q  <= vlen_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.VALUResult = res_q;
    assign bus.ALUFlags   = flags_q;
endmodule

// File: tb/tb_valu_seq.sv
// tb_valu_seq: random and directed scoreboard bench for valu_seq.
// A driver pushes expected responses; a monitor checks each done pulse.
module tb_valu_seq;
    localparam int WIDTH = 32;
    localparam int LANES = 5;
    localparam int VLW   = $clog2(LANES + 1);
    localparam int LW    = LANES * WIDTH;

    typedef struct {
        logic [LW-1:0] res;
        logic [3:0]    flags;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    valu_seq_if #(.WIDTH(WIDTH), .LANES(LANES)) bus ();

    valu_seq #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [LW-1:0] act,
                       input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic per lane
    function automatic exp_t model(input logic [2:0] op, input int vl,
                                   input logic [LW-1:0] a,
                                   input logic [LW-1:0] b);
        exp_t e;
        int n;
        logic [WIDTH-1:0] x, y, r;
        longint sx, sy, s;
        longint maxs, mins;
        logic fn, fz, fc, fv;
        maxs = (longint'(1) << (WIDTH - 1)) - 1;
        mins = -(longint'(1) << (WIDTH - 1));
        n = (vl > LANES) ? LANES : vl;
        e.res = '0;
        e.cyc = 0;
        fn = 0; fz = 1; fc = 0; fv = 0;
        for (int i = 0; i < n; i++) begin
            x = a[i*WIDTH +: WIDTH];
            y = b[i*WIDTH +: WIDTH];
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            r = '0;
            case (op)
                3'b000: begin
                    r = x + y;
                    s = sx + sy;
                    fc |= (longint'(x) + longint'(y)) >= (longint'(1) << WIDTH);
                    fv |= (s > maxs) || (s < mins);
                end
                3'b001: begin
                    r = x - y;
                    s = sx - sy;
                    fc |= (x >= y);
                    fv |= (s > maxs) || (s < mins);
                end
                3'b010: r = x & y;
                3'b011: r = x | y;
                3'b100: r = x ^ y;
                3'b110: r = x * y;
                default: r = '0;
            endcase
            e.res[i*WIDTH +: WIDTH] = r;
            fn |= r[WIDTH-1];
            if (r != 0) fz = 0;
        end
        e.flags = {fn, fz, fc, fv};
        return e;
    endfunction

    function automatic logic [LW-1:0] pack(input logic [WIDTH-1:0] w0,
        input logic [WIDTH-1:0] w1, input logic [WIDTH-1:0] w2,
        input logic [WIDTH-1:0] w3, input logic [WIDTH-1:0] w4);
        return {w4, w3, w2, w1, w0};
    endfunction

    function automatic logic [LW-1:0] rnd_vec();
        logic [LW-1:0] v;
        logic [WIDTH-1:0] w;
        for (int i = 0; i < LANES; i++) begin
            case ($urandom_range(0, 7))
                0: w = '0;
                1: w = 32'h7FFFFFFF;
                2: w = 32'h80000000;
                3: w = '1;
                4: w = 32'($urandom_range(0, 15));
                default: w = $urandom;
            endcase
            v[i*WIDTH +: WIDTH] = w;
        end
        return v;
    endfunction

    // Scoreboard monitor: compare each done pulse against the queue head
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.done) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cyc %0d expected none", cyc);
            end else begin
                e = q.pop_front();
                chk("result", bus.VALUResult, e.res);
                chk("flags", LW'(bus.ALUFlags), LW'(e.flags));
                chk("done_cycle", LW'(cyc), LW'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [2:0] op, input int vl,
                         input logic [LW-1:0] a, input logic [LW-1:0] b,
                         output exp_t e);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.ALUControl = op;
        bus.vlen       = VLW'(vl);
        bus.VsrcA      = a;
        bus.VsrcB      = b;
        @(posedge clk);
        #1;
        e = model(op, vl, a, b);
        e.cyc = cyc + ((op == 3'b110) ? WIDTH : 1);
        q.push_back(e);
        bus.start      = 1'b0;
        bus.ALUControl = 3'($urandom);
        bus.vlen       = VLW'($urandom);
        bus.VsrcA      = rnd_vec();
        bus.VsrcB      = rnd_vec();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        @(posedge clk);
    endtask

    initial begin
        exp_t e1, e2;
        int dones;
        bus.start = 1'b0;
        bus.ALUControl = '0;
        bus.vlen = '0;
        bus.VsrcA = '0;
        bus.VsrcB = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", LW'(bus.busy), '0);
        chk("rst_done", LW'(bus.done), '0);
        chk("rst_result", bus.VALUResult, '0);
        chk("rst_flags", LW'(bus.ALUFlags), '0);

        issue(3'b000, 5, pack(1, 32'h7FFFFFFF, 32'hFFFFFFFF, 5, 0),
              pack(2, 1, 1, 5, 0), e1);
        chk("vadd_flags_model", LW'(e1.flags), LW'(4'b1011));
        wait_drain();

        issue(3'b001, 2, pack(5, 3, 32'hFFFF, 32'hFFFF, 32'hFFFF),
              pack(5, 3, 32'hFFFF, 32'hFFFF, 32'hFFFF), e1);
        wait_drain();

        issue(3'b110, 3, pack(3, 32'hFFFFFFFF, 32'h10000, 0, 0),
              pack(7, 2, 32'h10000, 0, 0), e1);
        wait_drain();

        issue(3'b100, 0, rnd_vec(), rnd_vec(), e1);
        wait_drain();
        issue(3'b010, 7, '1, '1, e1);
        wait_drain();

        issue(3'b011, 5, rnd_vec(), rnd_vec(), e1);
        @(posedge clk);
        @(posedge clk);
        issue(3'b011, 4, rnd_vec(), rnd_vec(), e2);
        @(negedge clk);
        chk("hold_prev", bus.VALUResult, e1.res);
        wait_drain();

        issue(3'b110, 5, rnd_vec(), rnd_vec(), e1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.ALUControl = 3'b000;
        bus.VsrcA = rnd_vec();
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("abort_busy", LW'(bus.busy), '0);
        chk("abort_result", bus.VALUResult, '0);
        chk("abort_flags", LW'(bus.ALUFlags), '0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("abort_no_done", LW'(dones), '0);

        for (int k = 0; k < 40; k++) begin
            issue(3'($urandom), $urandom_range(0, 7), rnd_vec(), rnd_vec(), e1);
            wait_drain();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
